// File: rtl/tube_pkg.sv
// Shared types and constants for the 7-segment tube scan controller.
package tube_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_WAIT_DONE,
        ST_DWELL,
        ST_OFF
    } state_e;

    // Word handed to the serial driver; seg_n is shifted out first.
    typedef struct packed {
        logic [7:0] seg_n;
        logic [7:0] sel_n;
    } tube_word_t;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for hex 0..F, entry 0 rightmost.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [7:0]  SEG_BLANK = 8'hFF;
    localparam logic [15:0] WORD_OFF  = 16'hFFFF;

endpackage

// File: rtl/tube_scan_ctrl_hex_to_seg.sv
// Hex nibble to active-low segment byte, with blanking and decimal point.
module hex_to_seg
    import tube_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg_n_c
);

    logic [7:0] base;

    // Decimal point survives blanking so a lone dot can still be shown.
    always_comb begin
        base    = blank ? SEG_BLANK : SEG_TABLE[nibble];
        seg_n_c = {base[7] & ~dp, base[6:0]};
    end

endmodule

// File: rtl/tube_scan_ctrl.sv
// Round-robin digit scanner feeding the 74HC595 serial driver one word per digit.
module tube_scan_ctrl
    import tube_pkg::*;
#(
    parameter int unsigned DIGITS   = 6,
    parameter int unsigned DWELL    = 50000,
    parameter int unsigned BLANK_LZ = 0,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                  sysclk,
    input  logic                  rstn,
    input  logic                  disp_en,
    input  logic [4*DIGITS-1:0]   disp_data,
    input  logic [DIGITS-1:0]     dot_en,
    output logic                  req_tx,
    output logic [15:0]           data_tx,
    input  logic                  tx_done,
    output logic [2:0]            digit_idx,
    output logic                  err_timeout
);

    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam int unsigned DW_W   = $clog2(DWELL + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    tube_word_t          data_tx_q, data_tx_d;
    logic                req_tx_q, req_tx_d;
    logic                err_q, err_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [TO_W-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0]   snap_data_q, snap_data_d;
    logic [DIGITS-1:0]   snap_dot_q, snap_dot_d;

    logic [DATA_W-1:0]   src_data;
    logic [DIGITS-1:0]   src_dot;
    logic [3:0]          nib;
    logic                dp;
    logic                nz_above;
    logic                blank;
    logic [7:0]          sel_n;
    logic [7:0]          seg_n;

    // Digit 0 loads in the same cycle the frame snapshot is taken, so read live inputs then.
    always_comb begin
        src_data = (idx_q == 3'd0) ? disp_data : snap_data_q;
        src_dot  = (idx_q == 3'd0) ? dot_en    : snap_dot_q;
        nib      = 4'h0;
        dp       = 1'b0;
        nz_above = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == 3'(i)) begin
                nib = src_data[4*i +: 4];
                dp  = src_dot[i];
            end
            if ((3'(i) >= idx_q) && (src_data[4*i +: 4] != 4'h0)) begin
                nz_above = 1'b1;
            end
        end
        blank        = (BLANK_LZ != 0) && (idx_q != 3'd0) && !nz_above;
        sel_n        = 8'hFF;
        sel_n[idx_q] = 1'b0;
    end

    hex_to_seg u_hex_to_seg (
        .nibble  (nib),
        .dp      (dp),
        .blank   (blank),
        .seg_n_c (seg_n)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_tx_d   = data_tx_q;
        req_tx_d    = 1'b0;
        err_d       = err_q;
        dwell_d     = dwell_q;
        tmo_d       = tmo_q;
        snap_data_d = snap_data_q;
        snap_dot_d  = snap_dot_q;

        case (state_q)
            ST_IDLE: begin
                if (disp_en) begin
                    state_d = ST_LOAD;
                    idx_d   = 3'd0;
                end
            end
            ST_LOAD: begin
                if (idx_q == 3'd0) begin
                    snap_data_d = disp_data;
                    snap_dot_d  = dot_en;
                end
                data_tx_d = '{seg_n: seg_n, sel_n: sel_n};
                req_tx_d  = 1'b1;
                state_d   = ST_REQ;
            end
            ST_REQ: begin
                tmo_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    dwell_d = '0;
                    state_d = ST_DWELL;
                end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    req_tx_d = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DWELL: begin
                if (dwell_q == DW_W'(DWELL - 1)) begin
                    idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
                    if (disp_en) begin
                        state_d = ST_LOAD;
                    end else begin
                        data_tx_d = WORD_OFF;
                        req_tx_d  = 1'b1;
                        tmo_d     = '0;
                        state_d   = ST_OFF;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_OFF: begin
                // The cycle carrying req_tx is the issue slot; waiting starts after it.
                if (!req_tx_q) begin
                    if (tx_done) begin
                        state_d = ST_IDLE;
                    end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
                        err_d    = 1'b1;
                        req_tx_d = 1'b1;
                        tmo_d    = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            data_tx_q   <= WORD_OFF;
            req_tx_q    <= 1'b0;
            err_q       <= 1'b0;
            dwell_q     <= '0;
            tmo_q       <= '0;
            snap_data_q <= '0;
            snap_dot_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_tx_q   <= data_tx_d;
            req_tx_q    <= req_tx_d;
            err_q       <= err_d;
            dwell_q     <= dwell_d;
            tmo_q       <= tmo_d;
            snap_data_q <= snap_data_d;
            snap_dot_q  <= snap_dot_d;
        end
    end

    assign req_tx      = req_tx_q;
    assign data_tx     = data_tx_q;
    assign digit_idx   = idx_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Scoreboard bench for tube_scan_ctrl with a behavioural serial-driver responder.
module tb_tube_scan_ctrl;

    localparam int unsigned DIGITS  = 6;
    localparam int unsigned DWELL   = 20;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned XFER    = 20;

    typedef struct {
        logic [15:0] w;
        int          idx;
    } exp_t;

    logic        sysclk = 1'b0;
    logic        rstn = 1'b0;
    logic        disp_en = 1'b0;
    logic [23:0] disp_data = '0;
    logic [5:0]  dot_en = '0;
    logic        tx_done = 1'b0;
    logic        req_tx;
    logic [15:0] data_tx;
    logic [2:0]  digit_idx;
    logic        err_timeout;

    exp_t        sb[$];
    int          vecs = 0;
    int          errs = 0;
    int          cyc = 0;
    int          gap_cnt = 100000;
    int          last_req_cyc = 0;
    int          req_total = 0;
    int          xfer_cnt = 0;
    bit          busy = 1'b0;
    bit          unstable = 1'b0;
    bit          drv_en = 1'b1;
    bit          chk_gap = 1'b0;
    logic [15:0] cur_word = '0;
    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #10 sysclk = ~sysclk;

    tube_scan_ctrl #(
        .DIGITS   (DIGITS),
        .DWELL    (DWELL),
        .BLANK_LZ (1),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .sysclk      (sysclk),
        .rstn        (rstn),
        .disp_en     (disp_en),
        .disp_data   (disp_data),
        .dot_en      (dot_en),
        .req_tx      (req_tx),
        .data_tx     (data_tx),
        .tx_done     (tx_done),
        .digit_idx   (digit_idx),
        .err_timeout (err_timeout)
    );

    // Expected word for digit i with leading-zero blanking enabled.
    function automatic logic [15:0] model_word(input logic [23:0] d, input logic [5:0] dp, input int i);
        logic [3:0] n;
        logic [7:0] seg;
        logic [7:0] sel;
        bit         nz;
        nz = 1'b0;
        for (int j = i; j < 6; j++) begin
            n = d[4*j +: 4];
            if (n != 4'h0) nz = 1'b1;
        end
        n   = d[4*i +: 4];
        seg = (i > 0 && !nz) ? 8'hFF : seg_tab[n];
        if (dp[i]) seg[7] = 1'b0;
        sel    = 8'hFF;
        sel[i] = 1'b0;
        return {seg, sel};
    endfunction

    function automatic void push(input logic [15:0] w, input int idx);
        exp_t e;
        e.w   = w;
        e.idx = idx;
        sb.push_back(e);
    endfunction

    // Driver responder and scoreboard consumer, sampled on the falling edge.
    always @(negedge sysclk) begin
        exp_t e;
        cyc++;
        gap_cnt++;
        if (tx_done) tx_done = 1'b0;
        if (!rstn) begin
            busy    = 1'b0;
            gap_cnt = 100000;
        end else begin
            if (busy) begin
                if (data_tx !== cur_word) unstable = 1'b1;
                if (xfer_cnt == int'(XFER) - 1) begin
                    busy = 1'b0;
                    vecs++;
                    if (unstable) begin
                        errs++;
                        $display("FAIL data_stable: data_tx changed during transfer of %h", cur_word);
                    end
                    if (drv_en) begin
                        tx_done = 1'b1;
                        gap_cnt = 0;
                    end
                end else begin
                    xfer_cnt++;
                end
            end
            if (req_tx) begin
                req_total++;
                last_req_cyc = cyc;
                vecs++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_req: data_tx=%h at cycle %0d, required no request", data_tx, cyc);
                end else begin
                    e = sb.pop_front();
                    if (data_tx !== e.w) begin
                        errs++;
                        $display("FAIL word: data_tx=%h required %h", data_tx, e.w);
                    end
                    if (e.idx >= 0) begin
                        vecs++;
                        if (digit_idx !== 3'(e.idx)) begin
                            errs++;
                            $display("FAIL digit_idx: got %0d required %0d", digit_idx, e.idx);
                        end
                    end
                end
                if (chk_gap && gap_cnt < 1000) begin
                    vecs++;
                    if (gap_cnt != int'(DWELL) + 2) begin
                        errs++;
                        $display("FAIL dwell_gap: tx_done to req_tx %0d cycles, required %0d", gap_cnt, DWELL + 2);
                    end
                end
                busy     = 1'b1;
                xfer_cnt = 0;
                cur_word = data_tx;
                unstable = 1'b0;
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL drain_timeout: %0d words pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        disp_en = 1'b0;
        repeat (3) @(negedge sysclk);
        vecs += 4;
        if (req_tx !== 1'b0)         begin errs++; $display("FAIL reset_req: got %b required 0", req_tx); end
        if (data_tx !== 16'hFFFF)    begin errs++; $display("FAIL reset_data: got %h required ffff", data_tx); end
        if (digit_idx !== 3'd0)      begin errs++; $display("FAIL reset_idx: got %0d required 0", digit_idx); end
        if (err_timeout !== 1'b0)    begin errs++; $display("FAIL reset_err: got %b required 0", err_timeout); end
        #1 rstn = 1'b1;
        repeat (5) @(negedge sysclk);
        vecs++;
        if (req_tx !== 1'b0)         begin errs++; $display("FAIL idle_quiet: req_tx=%b required 0", req_tx); end
    endtask

    task automatic test_scan();
        disp_data = 24'h123456;
        dot_en    = '0;
        chk_gap   = 1'b1;
        push(16'h82FE, 0); push(16'h92FD, 1); push(16'h99FB, 2);
        push(16'hB0F7, 3); push(16'hA4EF, 4); push(16'hF9DF, 5);
        disp_en = 1'b1;
        wait_drain(2000);
        vecs++;
        if (err_timeout !== 1'b0) begin errs++; $display("FAIL scan_err: err_timeout=%b required 0", err_timeout); end
    endtask

    task automatic test_dot();
        dot_en = 6'b000100;
        push(16'h82FE, 0); push(16'h92FD, 1); push(16'h19FB, 2);
        push(16'hB0F7, 3); push(16'hA4EF, 4); push(16'hF9DF, 5);
        wait_drain(2000);
    endtask

    task automatic test_blank();
        dot_en    = '0;
        disp_data = 24'h000042;
        push(16'hA4FE, 0); push(16'h99FD, 1); push(16'hFFFB, 2);
        push(16'hFFF7, 3); push(16'hFFEF, 4); push(16'hFFDF, 5);
        wait_drain(2000);
        disp_data = 24'h000000;
        push(16'hC0FE, 0); push(16'hFFFD, 1); push(16'hFFFB, 2);
        push(16'hFFF7, 3); push(16'hFFEF, 4); push(16'hFFDF, 5);
        wait_drain(2000);
    endtask

    task automatic test_midframe();
        disp_data = 24'h123456;
        for (int i = 0; i < 4; i++) push(model_word(24'h123456, 6'b0, i), i);
        wait_drain(2000);
        disp_data = 24'hABCDEF;
        push(model_word(24'h123456, 6'b0, 4), 4);
        push(model_word(24'h123456, 6'b0, 5), 5);
        for (int i = 0; i < 6; i++) push(model_word(24'hABCDEF, 6'b0, i), i);
        wait_drain(3000);
    endtask

    task automatic test_disable();
        int r0;
        chk_gap = 1'b0;
        disp_en = 1'b0;
        push(16'hFFFF, -1);
        wait_drain(500);
        r0 = req_total;
        repeat (80) @(negedge sysclk);
        #1;
        vecs += 3;
        if (req_total != r0)      begin errs++; $display("FAIL off_quiet: %0d extra requests, required 0", req_total - r0); end
        if (data_tx !== 16'hFFFF) begin errs++; $display("FAIL off_word: data_tx=%h required ffff", data_tx); end
        if (req_tx !== 1'b0)      begin errs++; $display("FAIL off_req: req_tx=%b required 0", req_tx); end
        push(model_word(24'hABCDEF, 6'b0, 0), 0);
        push(model_word(24'hABCDEF, 6'b0, 1), 1);
        disp_en = 1'b1;
        wait_drain(1000);
    endtask

    task automatic test_timeout();
        int c1;
        int c2;
        drv_en = 1'b0;
        c1 = last_req_cyc;
        vecs++;
        if (err_timeout !== 1'b0) begin errs++; $display("FAIL pre_timeout_err: got %b required 0", err_timeout); end
        push(model_word(24'hABCDEF, 6'b0, 1), 1);
        wait_drain(500);
        c2 = last_req_cyc;
        vecs += 2;
        if (c2 - c1 != int'(TIMEOUT) + 1) begin errs++; $display("FAIL retry_time: re-request after %0d cycles, required %0d", c2 - c1, TIMEOUT + 1); end
        if (err_timeout !== 1'b1) begin errs++; $display("FAIL timeout_err: got %b required 1", err_timeout); end
    endtask

    task automatic test_reset_mid();
        @(negedge sysclk);
        rstn = 1'b0;
        @(negedge sysclk);
        #1;
        vecs += 4;
        if (req_tx !== 1'b0)      begin errs++; $display("FAIL mid_reset_req: got %b required 0", req_tx); end
        if (data_tx !== 16'hFFFF) begin errs++; $display("FAIL mid_reset_data: got %h required ffff", data_tx); end
        if (digit_idx !== 3'd0)   begin errs++; $display("FAIL mid_reset_idx: got %0d required 0", digit_idx); end
        if (err_timeout !== 1'b0) begin errs++; $display("FAIL mid_reset_err: got %b required 0", err_timeout); end
        drv_en = 1'b1;
        push(model_word(24'hABCDEF, 6'b0, 0), 0);
        rstn = 1'b1;
        wait_drain(500);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_dot();
        test_blank();
        test_midframe();
        test_disable();
        test_timeout();
        test_reset_mid();
        disp_en = 1'b0;
        repeat (5) @(negedge sysclk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
